// File: rtl/dem_switch_tree.sv
// dem_switch_tree: pipelined binary-tree DEM encoder turning a quantizer code into
// unit-element enables, with fixed, PN-randomised or first-order-shaped node splits.
module dem_switch_tree #(
    parameter int          LEVELS    = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    input  logic [LEVELS:0]          code_i,
    input  logic [1:0]               mode_i,
    output logic                     valid_o,
    output logic [(1<<LEVELS)-1:0]   elem_o,
    output logic                     code_err_o
);
    localparam int          N    = 1 << LEVELS;
    localparam int          W    = LEVELS + 1;
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    // Stage l holds the 2^l counts entering tree level l; stage LEVELS holds the leaves.
    logic [15:0]   lfsr_q, lfsr_d;
    logic [W-1:0]  cnt_q  [LEVELS+1][N];
    logic [W-1:0]  cnt_d  [LEVELS+1][N];
    logic [1:0]    mode_q [LEVELS+1];
    logic [1:0]    mode_d [LEVELS+1];
    logic [15:0]   snap_q [LEVELS+1];
    logic [15:0]   snap_d [LEVELS+1];
    logic [LEVELS:0] valid_q, valid_d, err_q, err_d;
    // Per-node shaping memory: 1 means the last odd split used s = +1.
    logic [N-2:0]  shp_q, shp_d;
    logic [W-1:0]  x, lo;
    logic          sp;
    int            k;

    always_comb begin
        lfsr_d  = valid_i ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
        valid_d = {valid_q[LEVELS-1:0], valid_i};
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        snap_d  = snap_q;
        err_d   = err_q;
        shp_d   = shp_q;
        x       = '0;
        lo      = '0;
        sp      = 1'b0;
        k       = 0;
        if (valid_i) begin
            cnt_d[0][0] = (code_i > W'(N)) ? W'(N) : code_i;
            mode_d[0]   = mode_i;
            snap_d[0]   = lfsr_q;
            err_d[0]    = code_i > W'(N);
        end
        for (int l = 0; l < LEVELS; l++) begin
            if (valid_q[l]) begin
                mode_d[l+1] = mode_q[l];
                snap_d[l+1] = snap_q[l];
                err_d[l+1]  = err_q[l];
                for (int j = 0; j < N / 2; j++) begin
                    if (j < (1 << l)) begin
                        x  = cnt_q[l][j];
                        k  = (1 << l) - 1 + j;
                        sp = (mode_q[l] == 2'd1) ? snap_q[l][k] :
                             (mode_q[l] == 2'd2) ? ~shp_q[k] : 1'b1;
                        lo = (x >> 1) + W'(x[0] & sp);
                        cnt_d[l+1][2*j]   = lo;
                        cnt_d[l+1][2*j+1] = x - lo;
                        if (mode_q[l] == 2'd2 && x[0])
                            shp_d[k] = sp;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_q  <= SEED;
            valid_q <= '0;
            err_q   <= '0;
            shp_q   <= '0;
            for (int l = 0; l <= LEVELS; l++) begin
                mode_q[l] <= '0;
                snap_q[l] <= '0;
                for (int j = 0; j < N; j++)
                    cnt_q[l][j] <= '0;
            end
        end else begin
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            shp_q   <= shp_d;
            mode_q  <= mode_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        valid_o    = valid_q[LEVELS];
        code_err_o = valid_q[LEVELS] & err_q[LEVELS];
        for (int i = 0; i < N; i++)
            elem_o[i] = cnt_q[LEVELS][i][0];
    end
endmodule

// File: tb/tb_dem_switch_tree.sv
// tb_dem_switch_tree: random and directed stimulus checked every cycle against
// a whole-sample tree model of the DEM encoder.
module tb_dem_switch_tree;
    localparam int LEVELS = 3;
    localparam int N      = 1 << LEVELS;

    logic            clk_i   = 1'b0;
    logic            reset_i = 1'b1;
    logic            valid_i = 1'b0;
    logic [LEVELS:0] code_i  = '0;
    logic [1:0]      mode_i  = '0;
    logic            valid_o;
    logic [N-1:0]    elem_o;
    logic            code_err_o;

    dem_switch_tree #(.LEVELS(LEVELS), .LFSR_SEED(16'hACE1)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .code_i(code_i),
        .mode_i(mode_i), .valid_o(valid_o), .elem_o(elem_o), .code_err_o(code_err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    typedef struct {
        int           cyc;
        logic [N-1:0] elem;
        logic         err;
        int           code;
    } exp_t;

    exp_t         q[$];
    int           compared   = 0;
    int           mismatched = 0;
    logic [15:0]  m_lfsr;
    int           m_last [N-1];
    logic [N-1:0] last_elem;
    exp_t         ex;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Splits a whole sample through the tree using the node rules directly.
    task automatic model(input int code, input int mode, output logic [N-1:0] elem);
        int x [2*N-1];
        int s;
        logic [15:0] snap;
        snap   = m_lfsr;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        x[0]   = (code > N) ? N : code;
        for (int n = 0; n < N - 1; n++) begin
            if (x[n] % 2 == 0) begin
                x[2*n+1] = x[n] / 2;
                x[2*n+2] = x[n] / 2;
            end else begin
                if (mode == 1) s = snap[n] ? 1 : -1;
                else if (mode == 2) begin
                    s = -m_last[n];
                    m_last[n] = s;
                end else s = 1;
                x[2*n+1] = (x[n] + s) / 2;
                x[2*n+2] = (x[n] - s) / 2;
            end
        end
        for (int i = 0; i < N; i++)
            elem[i] = (x[N-1+i] == 1);
    endtask

    task automatic drive(input bit v, input int c, input int m, output logic [N-1:0] e);
        exp_t t;
        @(posedge clk_i);
        #1;
        valid_i = v;
        code_i  = c[LEVELS:0];
        mode_i  = m[1:0];
        e       = '0;
        if (v) begin
            model(c, m, e);
            t.cyc  = cyc + 1 + LEVELS;
            t.elem = e;
            t.err  = (c > N);
            t.code = (c > N) ? N : c;
            q.push_back(t);
        end
    endtask

    task automatic idle(input int n);
        logic [N-1:0] d;
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, d);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        reset_i = 1'b1;
        #1;
        chk("reset_valid_o", 32'(valid_o), 32'd0);
        chk("reset_elem_o", 32'(elem_o), 32'd0);
        chk("reset_code_err_o", 32'(code_err_o), 32'd0);
        q.delete();
        m_lfsr = 16'hACE1;
        for (int n = 0; n < N - 1; n++) m_last[n] = -1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (reset_i) last_elem = '0;
        else if (valid_o) begin
            compared++;
            if (q.size() == 0 || q[0].cyc != cyc) begin
                mismatched++;
                $display("FAIL valid_o_timing: got valid_o=1 at cycle %0d expected next at %0d",
                         cyc, (q.size() != 0) ? q[0].cyc : -1);
            end else begin
                ex = q.pop_front();
                chk("elem_o", 32'(elem_o), 32'(ex.elem));
                chk("code_err_o", 32'(code_err_o), 32'(ex.err));
                chk("popcount", 32'($countones(elem_o)), 32'(ex.code));
            end
            last_elem = elem_o;
        end else begin
            chk("hold_elem_o", 32'(elem_o), 32'(last_elem));
            chk("idle_code_err_o", 32'(code_err_o), 32'd0);
            if (q.size() != 0 && q[0].cyc <= cyc) begin
                void'(q.pop_front());
                compared++;
                mismatched++;
                $display("FAIL missing_valid_o: got valid_o=0 expected 1 at cycle %0d", cyc);
            end
        end
    end

    logic [N-1:0] e;
    logic [N-1:0] shp_exp [4];

    initial begin
        shp_exp[0] = 8'h01; shp_exp[1] = 8'h10; shp_exp[2] = 8'h04; shp_exp[3] = 8'h40;
        do_reset();
        drive(1'b1, 8, 0, e);  chk("pin_full8", 32'(e), 32'h0FF);
        drive(1'b1, 5, 0, e);  chk("pin_code5", 32'(e), 32'h057);
        drive(1'b1, 0, 0, e);  chk("pin_code0", 32'(e), 32'h000);
        drive(1'b1, 1, 0, e);  chk("pin_code1", 32'(e), 32'h001);
        drive(1'b1, 12, 0, e); chk("pin_sat12", 32'(e), 32'h0FF);
        drive(1'b1, 5, 3, e);  chk("pin_mode3", 32'(e), 32'h057);
        idle(6);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1, 2, e);
            chk("pin_shape", 32'(e), 32'(shp_exp[i]));
        end
        idle(6);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1, 2, e);
            chk("pin_shape_bubbles", 32'(e), 32'(shp_exp[i]));
            idle(3);
        end
        for (int i = 0; i < 20; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 3), e);
        do_reset();
        for (int i = 0; i < 10000; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 8), 1, e);
        for (int i = 0; i < 2000; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 3), e);
        idle(LEVELS + 4);
        chk("drain_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
